ypc_seq: RTL and testbench

Program-counter sequencer sitting directly upstream of the fetch stage; its pc output drives the fetch stage's PCin.
- Once per enabled clock it consumes the current instruction, immediate, jump target and ALU zero flag, then registers the next PC: sequential, branch-taken or jal.
- Counts retired instructions and halts on ecall or on a programmable instruction budget.
- Replaces the ad-hoc next-PC logic in the lab benches.

---
 rtl/ypc_seq.sv | 108 ++++++++++
 tb/tb_ypc_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ypc_seq.sv
// rtl/ypc_seq.sv - program-counter sequencer feeding fetch PCin, with retire count and halt.
// Optional misalignment trap on taken targets: define YPC_MISALIGN_TRAP_EN.
module ypc_seq #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(128),
  parameter int              MAX_INSTR = 43
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jtarget,
  input  logic            zero,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_p4,
  output logic            taken,
  output logic [XLEN-1:0] retired,
  output logic            halted,
  output logic            err
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;

  logic [6:0]      opc;
  logic            is_br, is_jal, is_ecall, redirect;
  logic [XLEN-1:0] target, next_pc, load_pc, retired_p1;
  logic            misalign, budget_hit;
  logic            unused_bits;

  assign unused_bits = ^{ins[31:7], next_pc[1:0]};

  always_comb begin
    opc        = ins[6:0];
    is_br      = (opc == 7'h63);
    is_jal     = (opc == 7'h6F);
    is_ecall   = (opc == 7'h73);
    redirect   = (is_br && zero) || is_jal;
    pc_p4      = pc_q + XLEN'(4);
    target     = is_jal ? (pc_q + (jtarget << 2)) : (pc_q + (imm << 1));
    next_pc    = redirect ? target : pc_p4;
    retired_p1 = retired_q + XLEN'(1);
    budget_hit = (MAX_INSTR != 0) && (retired_p1 == XLEN'(MAX_INSTR));
`ifdef YPC_MISALIGN_TRAP_EN
    misalign   = redirect && (next_pc[1:0] != 2'b00);
    load_pc    = next_pc;
`else
    // Without the trap the target is silently word-aligned.
    misalign   = 1'b0;
    load_pc    = {next_pc[XLEN-1:2], 2'b00};
`endif
    taken      = redirect && (state_q == RUN);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    err_d     = err_q;
    if (state_q == RUN && en) begin
      if (misalign) begin
        err_d    = 1'b1;
        state_d  = HALT;
        halted_d = 1'b1;
      end else if (is_ecall) begin
        retired_d = retired_p1;
        state_d   = HALT;
        halted_d  = 1'b1;
      end else begin
        pc_d      = load_pc;
        retired_d = retired_p1;
        if (budget_hit) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign halted  = halted_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ypc_seq.sv
// tb/tb_ypc_seq.sv - directed-vector self-checking bench for ypc_seq.
module tb_ypc_seq;

  logic        clk = 1'b0;
  logic        reset, en, zero;
  logic [31:0] ins, imm, jtarget;
  logic [31:0] pc, pc_p4, retired;
  logic        taken, halted, err;
  logic [31:0] pc5, pc_p4_5, retired5;
  logic        taken5, halted5, err5;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] ADD  = 32'h0000_0033;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] ECAL = 32'h0000_0073;

  always #5 clk = ~clk;

  ypc_seq u_dut (
    .clk(clk), .reset(reset), .en(en), .ins(ins), .imm(imm), .jtarget(jtarget),
    .zero(zero), .pc(pc), .pc_p4(pc_p4), .taken(taken), .retired(retired),
    .halted(halted), .err(err)
  );

  ypc_seq #(.MAX_INSTR(5)) u_dut5 (
    .clk(clk), .reset(reset), .en(en), .ins(ins), .imm(imm), .jtarget(jtarget),
    .zero(zero), .pc(pc5), .pc_p4(pc_p4_5), .taken(taken5), .retired(retired5),
    .halted(halted5), .err(err5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic step(input logic e, input logic [31:0] i);
    en  = e;
    ins = i;
    @(posedge clk);
    #1;
    en  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; zero = 1'b0; ins = ADD; imm = '0; jtarget = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_pc", pc, 32'd128);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_pc_p4", pc_p4, 32'd132);

    // Sequential stepping, with an idle cycle in between
    step(1'b1, ADD); chk("seq1_pc", pc, 32'd132);
    step(1'b0, ADD); chk("hold_pc", pc, 32'd132);
    chk("hold_retired", retired, 32'd1);
    step(1'b1, ADD); chk("seq2_pc", pc, 32'd136);
    step(1'b1, ADD); chk("seq3_pc", pc, 32'd140);
    chk("seq_retired", retired, 32'd3);
    chk("seq_taken", {31'b0, taken}, 32'd0);

    // Branch taken at 140, imm=8 -> 156
    ins = BEQ; zero = 1'b1; imm = 32'd8; #1;
    chk("br_taken_comb", {31'b0, taken}, 32'd1);
    step(1'b1, BEQ); chk("br_taken_pc", pc, 32'd156);
    chk("br_retired", retired, 32'd4);

    // Branch not taken at 140 -> 144
    do_reset();
    step(1'b1, ADD); step(1'b1, ADD); step(1'b1, ADD);
    zero = 1'b0; ins = BEQ; #1;
    chk("br_nt_comb", {31'b0, taken}, 32'd0);
    step(1'b1, BEQ); chk("br_nt_pc", pc, 32'd144);

    // Reach 200 via branch, jal -2 -> 192, jal to 0xFFFFFFFC, then wrap to 0
    do_reset();
    zero = 1'b1; imm = 32'd36;
    step(1'b1, BEQ); chk("br_to_200", pc, 32'd200);
    jtarget = 32'hFFFF_FFFE; ins = JAL; #1;
    chk("jal_taken_comb", {31'b0, taken}, 32'd1);
    step(1'b1, JAL); chk("jal_back_pc", pc, 32'd192);
    jtarget = 32'hFFFF_FFCF;
    step(1'b1, JAL); chk("jal_to_top", pc, 32'hFFFF_FFFC);
    chk("top_pc_p4", pc_p4, 32'd0);
    step(1'b1, ADD); chk("wrap_pc", pc, 32'd0);
    chk("wrap_retired", retired, 32'd4);

    // Instruction budget of 5 on the second instance
    do_reset(); zero = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      step(1'b1, ADD);
      if (s == 4) chk("bud_s4_halted", {31'b0, halted5}, 32'd0);
      if (s == 5) begin
        chk("bud_s5_halted", {31'b0, halted5}, 32'd1);
        chk("bud_s5_pc", pc5, 32'd148);
      end
    end
    chk("bud_end_pc", pc5, 32'd148);
    chk("bud_end_retired", retired5, 32'd5);
    chk("bud_other_pc", pc, 32'd156);
    chk("bud_other_halted", {31'b0, halted}, 32'd0);
    ins = JAL; #1;
    chk("halt_taken_forced", {31'b0, taken5}, 32'd0);
    chk("run_taken_jal", {31'b0, taken}, 32'd1);
    do_reset();
    chk("halt_rst_pc", pc5, 32'd128);
    chk("halt_rst_retired", retired5, 32'd0);
    chk("halt_rst_halted", {31'b0, halted5}, 32'd0);

    // ecall at 136
    step(1'b1, ADD); step(1'b1, ADD);
    step(1'b1, ECAL);
    chk("ecall_pc", pc, 32'd136);
    chk("ecall_retired", retired, 32'd3);
    chk("ecall_halted", {31'b0, halted}, 32'd1);
    step(1'b1, ADD);
    chk("ecall_frozen_pc", pc, 32'd136);
    chk("ecall_frozen_ret", retired, 32'd3);
    // Reset and en together: reset wins
    reset = 1'b1;
    step(1'b1, ADD);
    reset = 1'b0;
    chk("rst_en_pc", pc, 32'd128);
    chk("rst_en_retired", retired, 32'd0);
    chk("rst_en_halted", {31'b0, halted}, 32'd0);

    // Misaligned taken target 130
    zero = 1'b1; imm = 32'd1;
    step(1'b1, BEQ);
    chk("mis_pc", pc, 32'd128);
`ifdef YPC_MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    chk("mis_retired", retired, 32'd0);
`else
    chk("mis_err", {31'b0, err}, 32'd0);
    chk("mis_halted", {31'b0, halted}, 32'd0);
    chk("mis_retired", retired, 32'd1);
    step(1'b1, ADD);
    chk("mis_continue_pc", pc, 32'd132);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
